// File: rtl/gpio_serial_loader.sv
// Shifts one PAD_CTRL_BITS word per GPIO into the control-block chain (highest index first), then strobes load.
// Optional chain readback is enabled by defining GPIO_LOADER_READBACK_EN.
module gpio_serial_loader #(
    parameter int NUM_GPIO      = 19,
    parameter int PAD_CTRL_BITS = 13,
    parameter int CLK_DIV       = 2,
    parameter int IDX_W         = 5
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_data,
    output logic                     serial_clock,
    output logic                     serial_load,
    output logic                     serial_resetn,
    output logic                     serial_data_out,
    input  logic                     serial_data_in
`ifdef GPIO_LOADER_READBACK_EN
    ,
    output logic                     rb_we,
    output logic [IDX_W-1:0]         rb_addr,
    output logic [PAD_CTRL_BITS-1:0] rb_data
`endif
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CLK_LO,
        S_CLK_HI,
        S_GAP,
        S_LOAD
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic [BIT_W-1:0]         bit_idx, bit_nxt;
    logic [PAD_CTRL_BITS-1:0] word, word_nxt;
    logic                     done_nxt;
    logic                     sdo_nxt;
    logic                     phase_end;

    assign phase_end     = (cnt == CNT_W'(CLK_DIV - 1));
    assign cfg_addr      = idx;
    assign serial_resetn = ~wb_rst_i;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        bit_nxt   = bit_idx;
        word_nxt  = word;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = IDX_W'(NUM_GPIO - 1);
                end
            end
            S_FETCH: begin
                word_nxt  = cfg_data;
                bit_nxt   = BIT_W'(PAD_CTRL_BITS - 1);
                state_nxt = S_CLK_LO;
            end
            S_CLK_LO: begin
                if (phase_end) state_nxt = S_CLK_HI;
            end
            S_CLK_HI: begin
                if (phase_end) begin
                    if (bit_idx != '0) begin
                        bit_nxt   = bit_idx - 1'b1;
                        state_nxt = S_CLK_LO;
                    end else if (idx != '0) begin
                        idx_nxt   = idx - 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (phase_end) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (phase_end) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Phase counter restarts on every state change and stays parked while idle.
        if ((state_nxt != state) || (state == S_IDLE)) cnt_nxt = '0;
        else                                           cnt_nxt = cnt + 1'b1;

        // Data is launched on entry to CLK_LO and held through CLK_HI.
        case (state_nxt)
            S_CLK_LO: sdo_nxt = word_nxt[bit_nxt];
            S_CLK_HI: sdo_nxt = serial_data_out;
            default:  sdo_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state           <= S_IDLE;
            cnt             <= '0;
            idx             <= '0;
            bit_idx         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_load     <= 1'b0;
            serial_data_out <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            idx             <= idx_nxt;
            bit_idx         <= bit_nxt;
            busy            <= (state_nxt != S_IDLE);
            done            <= done_nxt;
            serial_clock    <= (state_nxt == S_CLK_HI);
            serial_load     <= (state_nxt == S_LOAD);
            serial_data_out <= sdo_nxt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        word <= word_nxt;
    end

`ifdef GPIO_LOADER_READBACK_EN
    logic                     sample_edge;
    logic                     word_end;
    logic [PAD_CTRL_BITS-1:0] rb_shift;

    // The chain return is sampled on the same edge that raises serial_clock, i.e. before the chain shifts.
    assign sample_edge = (state == S_CLK_LO) && (state_nxt == S_CLK_HI);
    assign word_end    = (state == S_CLK_HI) && phase_end && (bit_idx == '0);

    always_ff @(posedge wb_clk_i) begin
        if (sample_edge) rb_shift <= {rb_shift[PAD_CTRL_BITS-2:0], serial_data_in};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rb_we   <= 1'b0;
            rb_addr <= '0;
            rb_data <= '0;
        end else begin
            rb_we <= word_end;
            if (word_end) begin
                rb_addr <= idx;
                rb_data <= rb_shift;
            end
        end
    end
`else
    logic unused_serial_data_in;
    assign unused_serial_data_in = serial_data_in;
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader with a two-block chain model; define GPIO_LOADER_READBACK_EN to cover readback.
module tb_gpio_serial_loader;

    localparam int NUM_GPIO = 2;
    localparam int PAD      = 13;
    localparam int CLK_DIV  = 2;
    localparam int IDX_W    = 5;
    localparam int XFER_CYC = NUM_GPIO * (1 + 2 * CLK_DIV * PAD) + 2 * CLK_DIV;

    typedef struct packed {
        logic [IDX_W-1:0] addr;
        logic [PAD-1:0]   data;
    } rb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [IDX_W-1:0] cfg_addr;
    logic [PAD-1:0]   cfg_data;
    logic             serial_clock, serial_load, serial_resetn, serial_data_out, serial_data_in;
`ifdef GPIO_LOADER_READBACK_EN
    logic             rb_we;
    logic [IDX_W-1:0] rb_addr;
    logic [PAD-1:0]   rb_data;
`endif

    logic [PAD-1:0] words     [NUM_GPIO];
    logic [PAD-1:0] sh        [NUM_GPIO];
    logic [PAD-1:0] regs      [NUM_GPIO];
    logic [PAD-1:0] chain_exp [NUM_GPIO];

    logic exp_bits[$];
    rb_t  rb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt, busy_cnt, done_cnt, load_cnt, rb_cnt;
    logic sc_prev = 1'b0;
    logic ld_prev = 1'b0;

    always #5 clk = ~clk;

    gpio_serial_loader #(
        .NUM_GPIO(NUM_GPIO), .PAD_CTRL_BITS(PAD), .CLK_DIV(CLK_DIV), .IDX_W(IDX_W)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .serial_clock(serial_clock),
        .serial_load(serial_load),
        .serial_resetn(serial_resetn),
        .serial_data_out(serial_data_out),
        .serial_data_in(serial_data_in)
`ifdef GPIO_LOADER_READBACK_EN
        ,
        .rb_we(rb_we),
        .rb_addr(rb_addr),
        .rb_data(rb_data)
`endif
    );

    assign cfg_data = words[cfg_addr[0]];

    // Chain of two control blocks: data enters block0, block1 feeds serial_data_in.
    always @(posedge serial_clock or negedge serial_resetn) begin
        if (!serial_resetn) begin
            sh[0] <= '0;
            sh[1] <= '0;
        end else begin
            sh[0] <= {sh[0][PAD-2:0], serial_data_out};
            sh[1] <= {sh[1][PAD-2:0], sh[0][PAD-1]};
        end
    end

    always @(posedge serial_load or negedge serial_resetn) begin
        if (!serial_resetn) begin
            regs[0] <= '0;
            regs[1] <= '0;
        end else begin
            regs[0] <= sh[0];
            regs[1] <= sh[1];
        end
    end

    assign serial_data_in = sh[1][PAD-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
        if (serial_clock && !sc_prev) begin
            edge_cnt++;
            check("edge_expected", 32'(exp_bits.size() > 0), 32'd1);
            if (exp_bits.size() > 0) check("sdo_bit", 32'(serial_data_out), 32'(exp_bits.pop_front()));
        end
        if (serial_load && !ld_prev) load_cnt++;
`ifdef GPIO_LOADER_READBACK_EN
        if (rb_we) begin
            rb_t e;
            rb_cnt++;
            check("rb_expected", 32'(rb_q.size() > 0), 32'd1);
            if (rb_q.size() > 0) begin
                e = rb_q.pop_front();
                check("rb_addr", 32'(rb_addr), 32'(e.addr));
                check("rb_data", 32'(rb_data), 32'(e.data));
            end
        end
`endif
        sc_prev = serial_clock;
        ld_prev = serial_load;
    end

    task automatic clear_counts();
        edge_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        load_cnt = 0;
        rb_cnt   = 0;
    endtask

    task automatic expect_transfer(input logic [PAD-1:0] w1, input logic [PAD-1:0] w0);
        rb_t e;
        for (int b = PAD - 1; b >= 0; b--) exp_bits.push_back(w1[b]);
        for (int b = PAD - 1; b >= 0; b--) exp_bits.push_back(w0[b]);
        for (int i = NUM_GPIO - 1; i >= 0; i--) begin
            e.addr = IDX_W'(i);
            e.data = chain_exp[i];
            rb_q.push_back(e);
        end
        chain_exp[1] = w1;
        chain_exp[0] = w0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cfg_addr"}, 32'(cfg_addr), 32'd0);
        check({tag, "_sclk"}, 32'(serial_clock), 32'd0);
        check({tag, "_sload"}, 32'(serial_load), 32'd0);
        check({tag, "_sdo"}, 32'(serial_data_out), 32'd0);
        check({tag, "_resetn"}, 32'(serial_resetn), 32'd0);
`ifdef GPIO_LOADER_READBACK_EN
        check({tag, "_rb_we"}, 32'(rb_we), 32'd0);
        check({tag, "_rb_data"}, 32'(rb_data), 32'd0);
`endif
    endtask

    task automatic check_chain(input string tag, input logic [PAD-1:0] w1, input logic [PAD-1:0] w0);
        check({tag, "_blk1"}, 32'(regs[1]), 32'(w1));
        check({tag, "_blk0"}, 32'(regs[0]), 32'(w0));
        check({tag, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
    endtask

    initial begin
        chain_exp[0] = '0;
        chain_exp[1] = '0;
        words[0] = '0;
        words[1] = '0;
        clear_counts();
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("resetn_released", 32'(serial_resetn), 32'd1);

        // Basic transfer
        words[1] = 13'h1A5B;
        words[0] = 13'h0F0F;
        clear_counts();
        expect_transfer(words[1], words[0]);
        pulse_start();
        wait_done(400);
        @(negedge clk);
        check("basic_edges", 32'(edge_cnt), 32'd26);
        check("basic_busy_cycles", 32'(busy_cnt), 32'(XFER_CYC));
        check("basic_done_count", 32'(done_cnt), 32'd1);
        check("basic_load_count", 32'(load_cnt), 32'd1);
        check_chain("basic", 13'h1A5B, 13'h0F0F);

        // start toggled repeatedly while busy
        words[1] = 13'h1234;
        words[0] = 13'h0ABC;
        clear_counts();
        expect_transfer(words[1], words[0]);
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            start = (i % 3) != 0;
        end
        start = 1'b0;
        wait_done(400);
        @(negedge clk);
        check("busy_start_edges", 32'(edge_cnt), 32'd26);
        check("busy_start_done_count", 32'(done_cnt), 32'd1);
        check("busy_start_busy_cycles", 32'(busy_cnt), 32'(XFER_CYC));
        check_chain("busy_start", 13'h1234, 13'h0ABC);

        // Reset after the 7th serial_clock edge aborts the transfer
        words[1] = 13'h1FFF;
        words[0] = 13'h0001;
        clear_counts();
        expect_transfer(words[1], words[0]);
        pulse_start();
        for (int i = 0; i < 300 && edge_cnt < 7; i++) begin
            @(negedge clk);
            #1;
        end
        check("abort_edge7", 32'(edge_cnt), 32'd7);
        rst = 1'b1;
        #1 check("abort_resetn_now", 32'(serial_resetn), 32'd0);
        @(negedge clk);
        check_reset_outputs("abort");
        check("abort_chain_blk1", 32'(regs[1]), 32'd0);
        exp_bits.delete();
        rb_q.delete();
        chain_exp[0] = '0;
        chain_exp[1] = '0;
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_load", 32'(load_cnt), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        words[1] = 13'h0AAA;
        words[0] = 13'h1555;
        clear_counts();
        expect_transfer(words[1], words[0]);
        pulse_start();
        wait_done(400);
        @(negedge clk);
        check("after_abort_edges", 32'(edge_cnt), 32'd26);
        check("after_abort_done_count", 32'(done_cnt), 32'd1);
        check_chain("after_abort", 13'h0AAA, 13'h1555);

        // start held through done gives a back-to-back transfer
        words[1] = 13'h1C3D;
        words[0] = 13'h02E1;
        clear_counts();
        expect_transfer(words[1], words[0]);
        expect_transfer(words[1], words[0]);
        @(negedge clk) start = 1'b1;
        wait_done(400);
        @(negedge clk);
        check("b2b_busy_after_done", 32'(busy), 32'd1);
        check("b2b_fetch_addr", 32'(cfg_addr), 32'(NUM_GPIO - 1));
        check("b2b_sclk_low", 32'(serial_clock), 32'd0);
        start = 1'b0;
        wait_done(400);
        @(negedge clk);
        check("b2b_edges", 32'(edge_cnt), 32'd52);
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'(2 * XFER_CYC));
        check_chain("b2b", 13'h1C3D, 13'h02E1);

        // Two consecutive transfers, patterns A then B
        words[1] = 13'h1357;
        words[0] = 13'h0246;
        clear_counts();
        expect_transfer(words[1], words[0]);
        pulse_start();
        wait_done(400);
        @(negedge clk);
        check_chain("pat_a", 13'h1357, 13'h0246);
        words[1] = 13'h0DEF;
        words[0] = 13'h1ABC;
        clear_counts();
        expect_transfer(words[1], words[0]);
        pulse_start();
        wait_done(400);
        @(negedge clk);
        check_chain("pat_b", 13'h0DEF, 13'h1ABC);
`ifdef GPIO_LOADER_READBACK_EN
        check("pat_b_rb_pulses", 32'(rb_cnt), 32'd2);
        check("rb_left", 32'(rb_q.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
